// File: rtl/mrd_mem_pkg.sv
// Shared constants, state encoding and bank-rotation helper for the mixed-radix
// ping-pong memory read/write sequencers.
package mrd_mem_pkg;

    localparam int N_BANK  = 5;
    localparam int MAX_RDX = 5;

    typedef logic [2:0] bank_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } rd_state_t;

    // (a + b) mod 5 for operands already in 0..4; no divider needed.
    function automatic bank_idx_t mod5_add(input bank_idx_t a, input bank_idx_t b);
        logic [3:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 4'd5) begin
            sum = sum - 4'd5;
        end
        return sum[2:0];
    endfunction

endpackage

// File: rtl/mrd_rdx2345_if.sv
// One butterfly's worth of legs passed between the sample memory and the
// radix-2/3/4/5 switch, with bank coordinates for in-place write-back.
interface mrd_rdx2345_if #(
    parameter int DW  = 16,
    parameter int AW  = 8,
    parameter int TWW = 12
);
    logic [2:0]     factor;
    logic           valid;
    logic [DW-1:0]  d_real      [0:4];
    logic [DW-1:0]  d_imag      [0:4];
    logic [2:0]     bank_index  [0:4];
    logic [AW-1:0]  bank_addr   [0:4];
    logic [TWW-1:0] twdl_numrtr [0:4];

    modport from_mem (output factor, valid, d_real, d_imag, bank_index, bank_addr, twdl_numrtr);
    modport sw       (input  factor, valid, d_real, d_imag, bank_index, bank_addr, twdl_numrtr);
endinterface

// File: rtl/mrd_rd_delay.sv
// Fixed-depth register pipeline that keeps issue-side context aligned with the
// bank read data returning DEPTH cycles later.
module mrd_rd_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_pipe
            logic [W-1:0] stage_reg [0:DEPTH-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_reg[i] <= '0;
                    end
                end else begin
                    stage_reg[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mrd_mem_rdx2345_rd.sv
// Read-side sequencer for one ping-pong memory: sweeps a stage's butterflies,
// reads five rotated banks per cycle and presents the legs in leg order.
module mrd_mem_rdx2345_rd
    import mrd_mem_pkg::*;
#(
    parameter int DW     = 16,
    parameter int AW     = 8,
    parameter int TWW    = 12,
    parameter int RD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2:0]             factor,
    input  logic [AW:0]            n_bfly,
    input  logic [AW-1:0]          twdl_period,
    output logic                   busy,
    output logic                   done,
    output logic [N_BANK-1:0]      mem_rd_en,
    output logic [N_BANK*AW-1:0]   mem_rd_addr,
    input  logic [N_BANK*DW-1:0]   mem_rd_real,
    input  logic [N_BANK*DW-1:0]   mem_rd_imag,
    mrd_rdx2345_if.from_mem        to_sw
);

    localparam int DCW = $clog2(RD_LAT + 2);
    localparam int PW  = 1 + 3 + AW + AW;

    rd_state_t       state_reg, state_next;
    logic [AW-1:0]   bcnt_reg, bcnt_next;
    bank_idx_t       rot_reg, rot_next;
    logic [AW-1:0]   tcnt_reg, tcnt_next;
    logic [DCW-1:0]  drain_reg, drain_next;
    logic [2:0]      factor_reg, factor_next;
    logic [AW:0]     n_bfly_reg, n_bfly_next;
    logic [AW-1:0]   tp_reg, tp_next;

    logic            start_ok;
    logic            last_issue;
    logic            issue;

    assign start_ok = start && (factor >= 3'd2) && (factor <= 3'd5) &&
                      (n_bfly != '0) && (n_bfly <= {1'b1, {AW{1'b0}}}) &&
                      (twdl_period != '0);
    assign last_issue = ({1'b0, bcnt_reg} == (n_bfly_reg - 1'b1));
    assign issue      = (state_reg == ST_RUN);
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            bcnt_reg   <= '0;
            rot_reg    <= '0;
            tcnt_reg   <= '0;
            drain_reg  <= '0;
            factor_reg <= '0;
            n_bfly_reg <= '0;
            tp_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            bcnt_reg   <= bcnt_next;
            rot_reg    <= rot_next;
            tcnt_reg   <= tcnt_next;
            drain_reg  <= drain_next;
            factor_reg <= factor_next;
            n_bfly_reg <= n_bfly_next;
            tp_reg     <= tp_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        bcnt_next   = bcnt_reg;
        rot_next    = rot_reg;
        tcnt_next   = tcnt_reg;
        drain_next  = drain_reg;
        factor_next = factor_reg;
        n_bfly_next = n_bfly_reg;
        tp_next     = tp_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_ok) begin
                    factor_next = factor;
                    n_bfly_next = n_bfly;
                    tp_next     = twdl_period;
                    bcnt_next   = '0;
                    rot_next    = '0;
                    tcnt_next   = '0;
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_issue) begin
                    drain_next = '0;
                    state_next = ST_DRAIN;
                end else begin
                    bcnt_next = bcnt_reg + 1'b1;
                    rot_next  = (rot_reg == 3'd4) ? 3'd0 : rot_reg + 3'd1;
                    tcnt_next = (tcnt_reg == tp_reg - 1'b1) ? '0 : tcnt_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                // RD_LAT+1 cycles lets the last read land in the output register.
                if (drain_reg == DCW'(RD_LAT)) begin
                    state_next = ST_DONE;
                end else begin
                    drain_next = drain_reg + 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en   = '0;
        mem_rd_addr = '0;
        if (issue) begin
            for (int j = 0; j < N_BANK; j++) begin
                mem_rd_en[mod5_add(bank_idx_t'(j), rot_reg)] = (3'(j) < factor_reg);
                mem_rd_addr[j*AW +: AW] = bcnt_reg;
            end
        end
    end

    logic [PW-1:0]  pipe_out;
    logic           valid_d;
    bank_idx_t      rot_d;
    logic [AW-1:0]  bcnt_d;
    logic [AW-1:0]  tcnt_d;

    mrd_rd_delay #(
        .W     (PW),
        .DEPTH (RD_LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({issue, rot_reg, bcnt_reg, tcnt_reg}),
        .dout  (pipe_out)
    );

    assign {valid_d, rot_d, bcnt_d, tcnt_d} = pipe_out;

    logic [DW-1:0]  bank_real [0:N_BANK-1];
    logic [DW-1:0]  bank_imag [0:N_BANK-1];
    bank_idx_t      leg_bank  [0:N_BANK-1];
    logic [DW-1:0]  leg_real  [0:N_BANK-1];
    logic [DW-1:0]  leg_imag  [0:N_BANK-1];
    logic [TWW-1:0] leg_twdl  [0:N_BANK-1];

    // Un-rotate: leg j came from bank (j + rot) mod 5 when it was issued.
    for (genvar gi = 0; gi < N_BANK; gi++) begin : g_leg
        logic [AW+2:0] tw_full;
        logic          leg_used;

        assign bank_real[gi] = mem_rd_real[gi*DW +: DW];
        assign bank_imag[gi] = mem_rd_imag[gi*DW +: DW];
        assign leg_bank[gi]  = mod5_add(bank_idx_t'(gi), rot_d);
        assign leg_used      = (3'(gi) < factor_reg);
        assign leg_real[gi]  = leg_used ? bank_real[leg_bank[gi]] : '0;
        assign leg_imag[gi]  = leg_used ? bank_imag[leg_bank[gi]] : '0;
        assign tw_full       = (AW+3)'(gi) * {3'b000, tcnt_d};
        assign leg_twdl[gi]  = TWW'(tw_full);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_sw.valid  <= 1'b0;
            to_sw.factor <= '0;
            for (int j = 0; j < N_BANK; j++) begin
                to_sw.d_real[j]      <= '0;
                to_sw.d_imag[j]      <= '0;
                to_sw.bank_index[j]  <= '0;
                to_sw.bank_addr[j]   <= '0;
                to_sw.twdl_numrtr[j] <= '0;
            end
        end else begin
            to_sw.valid <= valid_d;
            if (valid_d) begin
                to_sw.factor <= factor_reg;
                for (int j = 0; j < N_BANK; j++) begin
                    to_sw.d_real[j]      <= leg_real[j];
                    to_sw.d_imag[j]      <= leg_imag[j];
                    to_sw.bank_index[j]  <= leg_bank[j];
                    to_sw.bank_addr[j]   <= bcnt_d;
                    to_sw.twdl_numrtr[j] <= leg_twdl[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_mrd_mem_rdx2345_rd.sv
// Randomised and directed stages checked cycle-by-cycle against a reference
// model of the read sequencer built from stage parameters and bank contents.
`timescale 1ns/1ps
module tb_mrd_mem_rdx2345_rd;

    localparam int DW     = 16;
    localparam int AW     = 8;
    localparam int TWW    = 12;
    localparam int RD_LAT = 2;
    localparam int MAXC   = 8192;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [2:0]       factor;
    logic [AW:0]      n_bfly;
    logic [AW-1:0]    twdl_period;
    logic             busy;
    logic             done;
    logic [4:0]       mem_rd_en;
    logic [5*AW-1:0]  mem_rd_addr;
    logic [5*DW-1:0]  mem_rd_real;
    logic [5*DW-1:0]  mem_rd_imag;

    always #5 clk = ~clk;

    mrd_rdx2345_if #(.DW(DW), .AW(AW), .TWW(TWW)) sw_if ();

    mrd_mem_rdx2345_rd #(.DW(DW), .AW(AW), .TWW(TWW), .RD_LAT(RD_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .factor      (factor),
        .n_bfly      (n_bfly),
        .twdl_period (twdl_period),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_real (mem_rd_real),
        .mem_rd_imag (mem_rd_imag),
        .to_sw       (sw_if)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 0;
    bit count_en = 0;
    logic [15:0] salt;
    int last_t;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] bank_word(input int b, input int a, input logic [15:0] s);
        return DW'((b << 12) | (a & 255)) ^ DW'(s);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Bank memories: data = {bank, addr} scrambled by salt, RD_LAT-cycle read.
    logic [DW-1:0] pipe_r [0:4][0:RD_LAT-1];
    logic [DW-1:0] pipe_i [0:4][0:RD_LAT-1];
    int rd_count [0:4][0:255];

    always @(posedge clk) begin
        for (int b = 0; b < 5; b++) begin
            for (int k = RD_LAT - 1; k > 0; k--) begin
                pipe_r[b][k] <= pipe_r[b][k-1];
                pipe_i[b][k] <= pipe_i[b][k-1];
            end
            if (mem_rd_en[b]) begin
                pipe_r[b][0] <= bank_word(b, int'(mem_rd_addr[b*AW +: AW]), salt);
                pipe_i[b][0] <= bank_word(b, int'(mem_rd_addr[b*AW +: AW]), ~salt);
                if (count_en)
                    rd_count[b][int'(mem_rd_addr[b*AW +: AW])] <= rd_count[b][int'(mem_rd_addr[b*AW +: AW])] + 1;
            end else begin
                pipe_r[b][0] <= DW'($urandom);
                pipe_i[b][0] <= DW'($urandom);
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 5; b++) begin
            mem_rd_real[b*DW +: DW] = pipe_r[b][RD_LAT-1];
            mem_rd_imag[b*DW +: DW] = pipe_i[b][RD_LAT-1];
        end
    end

    // Expected per-cycle behaviour and expected output transactions.
    typedef struct packed {
        logic [2:0]            f;
        logic [4:0][DW-1:0]    r;
        logic [4:0][DW-1:0]    i;
        logic [4:0][2:0]       bi;
        logic [4:0][AW-1:0]    ba;
        logic [4:0][TWW-1:0]   tw;
    } txn_t;

    logic          exp_busy  [0:MAXC-1];
    logic          exp_done  [0:MAXC-1];
    logic          exp_valid [0:MAXC-1];
    logic          exp_issue [0:MAXC-1];
    logic [4:0]    exp_en    [0:MAXC-1];
    logic [AW-1:0] exp_addr  [0:MAXC-1];
    txn_t          exp_q [$];

    always @(negedge clk) begin
        if (mon_en && cyc < MAXC) begin
            chk("busy",  64'(busy),        64'(exp_busy[cyc]));
            chk("done",  64'(done),        64'(exp_done[cyc]));
            chk("valid", 64'(sw_if.valid), 64'(exp_valid[cyc]));
            chk("rd_en", 64'(mem_rd_en),   64'(exp_en[cyc]));
            if (exp_issue[cyc])
                chk("rd_addr", 64'(mem_rd_addr), 64'({5{exp_addr[cyc]}}));
            if (exp_valid[cyc]) begin
                if (exp_q.size() == 0) begin
                    chk("model_queue", 64'(0), 64'(1));
                end else begin
                    txn_t x;
                    x = exp_q.pop_front();
                    if (sw_if.valid) begin
                        chk("factor", 64'(sw_if.factor), 64'(x.f));
                        for (int j = 0; j < 5; j++) begin
                            chk("d_real",      64'(sw_if.d_real[j]),      64'(x.r[j]));
                            chk("d_imag",      64'(sw_if.d_imag[j]),      64'(x.i[j]));
                            chk("bank_index",  64'(sw_if.bank_index[j]),  64'(x.bi[j]));
                            chk("bank_addr",   64'(sw_if.bank_addr[j]),   64'(x.ba[j]));
                            chk("twdl_numrtr", 64'(sw_if.twdl_numrtr[j]), 64'(x.tw[j]));
                        end
                    end
                end
            end
        end
    end

    // Drive one start pulse; when ok, record everything the stage should produce.
    task automatic launch(input int f, input int n, input int tp, input bit ok, output int done_c);
        int t;
        txn_t x;
        logic [4:0] en;
        @(negedge clk);
        t = cyc;
        last_t = t;
        start = 1'b1;
        factor = 3'(f);
        n_bfly = (AW+1)'(n);
        twdl_period = AW'(tp);
        done_c = t;
        if (ok) begin
            for (int k = 0; k < n; k++) begin
                en = '0;
                for (int j = 0; j < f; j++) en[(j + k) % 5] = 1'b1;
                exp_issue[t+1+k] = 1'b1;
                exp_en[t+1+k]    = en;
                exp_addr[t+1+k]  = AW'(k);
                exp_valid[t+RD_LAT+2+k] = 1'b1;
                x.f = 3'(f);
                for (int j = 0; j < 5; j++) begin
                    x.bi[j] = 3'((j + k) % 5);
                    x.ba[j] = AW'(k);
                    x.r[j]  = (j < f) ? bank_word((j + k) % 5, k, salt)  : '0;
                    x.i[j]  = (j < f) ? bank_word((j + k) % 5, k, ~salt) : '0;
                    x.tw[j] = TWW'((j * (k % tp)) % (1 << TWW));
                end
                exp_q.push_back(x);
            end
            done_c = t + n + RD_LAT + 2;
            for (int c = t + 1; c <= done_c; c++) exp_busy[c] = 1'b1;
            exp_done[done_c] = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int dc, dc2, bad;
        for (int c = 0; c < MAXC; c++) begin
            exp_busy[c] = 0; exp_done[c] = 0; exp_valid[c] = 0;
            exp_issue[c] = 0; exp_en[c] = '0; exp_addr[c] = '0;
        end
        salt = 16'($urandom);
        rst_n = 1'b0; start = 1'b0; factor = '0; n_bfly = '0; twdl_period = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_rd_en", 64'(mem_rd_en), 0);
        chk("rst_rd_addr", 64'(mem_rd_addr), 0);
        chk("rst_valid", 64'(sw_if.valid), 0);
        chk("rst_factor", 64'(sw_if.factor), 0);
        for (int j = 0; j < 5; j++) begin
            chk("rst_d_real", 64'(sw_if.d_real[j]), 0);
            chk("rst_twdl", 64'(sw_if.twdl_numrtr[j]), 0);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Normal stage and radix-2 stage
        launch(5, 7, 3, 1, dc);  wait_cyc(dc + 2);
        launch(2, 4, 3, 1, dc);  wait_cyc(dc + 2);

        // Rejected launches, then a start while busy
        launch(1, 5, 3, 0, dc);  wait_cyc(dc + 4);
        launch(3, 0, 3, 0, dc);  wait_cyc(dc + 4);
        launch(4, 5, 0, 0, dc);  wait_cyc(dc + 4);
        launch(6, 5, 3, 0, dc);  wait_cyc(dc + 4);
        launch(3, 10, 4, 1, dc);
        repeat (2) @(negedge clk);
        launch(5, 30, 2, 0, dc2);
        wait_cyc(dc + 2);

        // Full address sweep
        count_en = 1'b1;
        launch(5, 256, 7, 1, dc);  wait_cyc(dc + 2);
        count_en = 1'b0;
        bad = 0;
        for (int b = 0; b < 5; b++)
            for (int a = 0; a < 256; a++)
                if (rd_count[b][a] != 1) bad++;
        chk("sweep_reads", 64'(bad), 0);

        // Reset on the third issue cycle aborts the stage
        launch(5, 20, 4, 1, dc);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int c = last_t + 4; c <= dc + 2; c++) begin
            exp_busy[c] = 0; exp_done[c] = 0; exp_valid[c] = 0;
            exp_issue[c] = 0; exp_en[c] = '0;
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_valid", 64'(sw_if.valid), 0);
        chk("abort_d_real", 64'(sw_if.d_real[0]), 0);
        chk("abort_rd_addr", 64'(mem_rd_addr), 0);
        repeat (4) @(negedge clk);
        launch(4, 9, 5, 1, dc);  wait_cyc(dc + 2);

        // Back-to-back stages
        launch(3, 6, 2, 1, dc);  wait_cyc(dc);
        launch(5, 8, 3, 1, dc);  wait_cyc(dc + 2);

        // Random stages, sometimes back-to-back
        for (int it = 0; it < 8; it++) begin
            launch(int'($urandom_range(2, 5)), int'($urandom_range(1, 40)),
                   int'($urandom_range(1, 12)), 1, dc);
            if ($urandom_range(0, 1) == 1) wait_cyc(dc);
            else wait_cyc(dc + 1 + int'($urandom_range(0, 3)));
        end
        wait_cyc(dc + 4);
        chk("model_drained", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
